// File: rtl/ycbcr2rgb.sv
// Four-stage BT.601 full-range YCbCr -> RGB888 converter with DE/HSYNC/VSYNC delayed to match.
// Optional output saturation: define YCBCR2RGB_CLAMP_EN; otherwise results wrap modulo 256.
module ycbcr2rgb #(
    parameter int COEF_FRAC = 14,
    parameter int OFFSET    = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_in,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [23:0] pixel_in,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic [23:0] pixel_out
);

    // Integer form of round(c * 2^COEF_FRAC); 64-bit keeps the scaled constants exact.
    localparam logic signed [17:0] KR_CR = 18'(((64'd1402   << COEF_FRAC) + 64'd500)    / 64'd1000);
    localparam logic signed [17:0] KG_CB = 18'(((64'd344136 << COEF_FRAC) + 64'd500000) / 64'd1000000);
    localparam logic signed [17:0] KG_CR = 18'(((64'd714136 << COEF_FRAC) + 64'd500000) / 64'd1000000);
    localparam logic signed [17:0] KB_CB = 18'(((64'd1772   << COEF_FRAC) + 64'd500)    / 64'd1000);
    localparam logic signed [25:0] HALF  = 26'sd1 <<< (COEF_FRAC - 1);

    // S1 registers
    logic        [8:0]  y1_q;
    logic signed [8:0]  cbo_q, cro_q;
    logic signed [8:0]  cbo_d, cro_d;
    // S2 registers
    logic signed [25:0] ys_q, pr_q, pgb_q, pgr_q, pb_q;
    // S3 registers, index 0/1/2 = R/G/B
    logic signed [25:0] s_q [3];
    // S4 / output registers
    logic        [23:0] pixel_q, pixel_d;
    // Sync chain, each entry {de, h_sync, v_sync}
    logic [3:0][2:0]    sync_q;

    logic [7:0] ch [3];
`ifdef YCBCR2RGB_CLAMP_EN
    logic signed [11:0] rnd [3];
`else
    logic        [7:0]  rnd [3];
`endif

    assign cbo_d = 9'({1'b0, pixel_in[15:8]} - 9'(OFFSET));
    assign cro_d = 9'({1'b0, pixel_in[7:0]}  - 9'(OFFSET));

    always_comb begin
        for (int i = 0; i < 3; i++) begin
`ifdef YCBCR2RGB_CLAMP_EN
            rnd[i] = 12'((s_q[i] + HALF) >>> COEF_FRAC);
            if (rnd[i][11])
                ch[i] = 8'h00;
            else if (|rnd[i][10:8])
                ch[i] = 8'hFF;
            else
                ch[i] = rnd[i][7:0];
`else
            rnd[i] = 8'((s_q[i] + HALF) >>> COEF_FRAC);
            ch[i]  = rnd[i];
`endif
        end
        // Blank using the DE that travels alongside the S3 data.
        pixel_d = sync_q[2][2] ? {ch[0], ch[1], ch[2]} : 24'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y1_q    <= '0;
            cbo_q   <= '0;
            cro_q   <= '0;
            ys_q    <= '0;
            pr_q    <= '0;
            pgb_q   <= '0;
            pgr_q   <= '0;
            pb_q    <= '0;
            for (int i = 0; i < 3; i++) s_q[i] <= '0;
            pixel_q <= '0;
            sync_q  <= '0;
        end else begin
            y1_q    <= {1'b0, pixel_in[23:16]};
            cbo_q   <= cbo_d;
            cro_q   <= cro_d;

            ys_q    <= 26'(y1_q) << COEF_FRAC;
            pr_q    <= 26'(cro_q) * 26'(KR_CR);
            pgb_q   <= 26'(cbo_q) * 26'(KG_CB);
            pgr_q   <= 26'(cro_q) * 26'(KG_CR);
            pb_q    <= 26'(cbo_q) * 26'(KB_CB);

            s_q[0]  <= ys_q + pr_q;
            s_q[1]  <= ys_q - pgb_q - pgr_q;
            s_q[2]  <= ys_q + pb_q;

            pixel_q <= pixel_d;
            sync_q  <= {sync_q[2:0], {de_in, h_sync_in, v_sync_in}};
        end
    end

    assign de_out     = sync_q[3][2];
    assign h_sync_out = sync_q[3][1];
    assign v_sync_out = sync_q[3][0];
    assign pixel_out  = pixel_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed and reference-model checks for ycbcr2rgb (default COEF_FRAC=14, OFFSET=128).
module tb_ycbcr2rgb;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_in, h_sync_in, v_sync_in;
    logic [23:0] pixel_in;
    logic        de_out, h_sync_out, v_sync_out;
    logic [23:0] pixel_out;

    int n_checks = 0;
    int n_fail   = 0;

    ycbcr2rgb dut (
        .clk        (clk),
        .rst        (rst),
        .de_in      (de_in),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .pixel_in   (pixel_in),
        .de_out     (de_out),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out),
        .pixel_out  (pixel_out)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                         input logic de, input logic h, input logic v);
        pixel_in  = {y, cb, cr};
        de_in     = de;
        h_sync_in = h;
        v_sync_in = v;
    endtask

    function automatic logic [7:0] to8(input int v);
`ifdef YCBCR2RGB_CLAMP_EN
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
`endif
        return v[7:0];
    endfunction

    // Bit-exact model at COEF_FRAC=14, written with plain integer arithmetic.
    function automatic logic [23:0] ref_rgb(input logic [23:0] p);
        int y, cbo, cro, r, g, b;
        y   = int'(p[23:16]);
        cbo = int'(p[15:8]) - 128;
        cro = int'(p[7:0])  - 128;
        r = (y * 16384 + cro * 22970 + 8192) >>> 14;
        g = (y * 16384 - cbo * 5638 - cro * 11700 + 8192) >>> 14;
        b = (y * 16384 + cbo * 29032 + 8192) >>> 14;
        return {to8(r), to8(g), to8(b)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(8'd200, 8'd10, 8'd240, 1'b1, 1'b1, 1'b1);
        cyc();
        cyc();
        n_checks++;
        if ({de_out, h_sync_out, v_sync_out, pixel_out} !== 27'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %b %b %b %h, want 0 0 0 000000",
                     de_out, h_sync_out, v_sync_out, pixel_out);
        end
        drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_latency();
        drive(8'd128, 8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        n_checks++;
        if (de_out !== 1'b0 || pixel_out !== 24'h0) begin
            n_fail++;
            $display("FAIL latency_early: got de=%b pix=%h, want de=0 pix=000000", de_out, pixel_out);
        end
        cyc();
        n_checks++;
        if (de_out !== 1'b1 || pixel_out !== 24'h808080) begin
            n_fail++;
            $display("FAIL latency_grey: got de=%b pix=%h, want de=1 pix=808080", de_out, pixel_out);
        end
        cyc();
        n_checks++;
        if (de_out !== 1'b0 || pixel_out !== 24'h0) begin
            n_fail++;
            $display("FAIL latency_after: got de=%b pix=%h, want de=0 pix=000000", de_out, pixel_out);
        end
    endtask

    task automatic test_levels();
        logic [23:0] vin [5];
        logic [23:0] vexp [5];
        vin[0] = 24'h808080; vexp[0] = 24'h808080;
        vin[1] = 24'hFF8080; vexp[1] = 24'hFFFFFF;
        vin[2] = 24'h008080; vexp[2] = 24'h000000;
`ifdef YCBCR2RGB_CLAMP_EN
        vin[3] = 24'h000000; vexp[3] = 24'h008700;
        vin[4] = 24'hFFFFFF; vexp[4] = 24'hFF79FF;
`else
        vin[3] = 24'h000000; vexp[3] = 24'h4D871D;
        vin[4] = 24'hFFFFFF; vexp[4] = 24'hB179E0;
`endif
        for (int c = 0; c < 8; c++) begin
            if (c < 5) drive(vin[c][23:16], vin[c][15:8], vin[c][7:0], 1'b1, 1'b0, 1'b0);
            else       drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
            cyc();
            if (c >= 3) begin
                n_checks++;
                if (de_out !== 1'b1 || pixel_out !== vexp[c-3]) begin
                    n_fail++;
                    $display("FAIL levels[%0d] in=%h: got de=%b pix=%h, want de=1 pix=%h",
                             c - 3, vin[c-3], de_out, pixel_out, vexp[c-3]);
                end
            end
        end
        cyc();
    endtask

    task automatic test_blanking();
        drive(8'd255, 8'd128, 8'd128, 1'b0, 1'b1, 1'b1);
        cyc();
        drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        cyc();
        n_checks++;
        if ({de_out, h_sync_out, v_sync_out} !== 3'b011 || pixel_out !== 24'h0) begin
            n_fail++;
            $display("FAIL blanking: got sync=%b%b%b pix=%h, want sync=011 pix=000000",
                     de_out, h_sync_out, v_sync_out, pixel_out);
        end
        cyc();
    endtask

    task automatic test_random_stream();
        localparam int N = 300;
        logic [26:0] hist [N];
        logic [26:0] want;
        logic [23:0] p;
        logic [2:0]  s;
        for (int c = 0; c < N + 3; c++) begin
            if (c < N) begin
                p = 24'($urandom);
                s = 3'($urandom);
                // Second half toggles DE every cycle to exercise back-to-back gaps.
                if (c >= N / 2) s[2] = c[0];
                hist[c] = {s, p};
                drive(p[23:16], p[15:8], p[7:0], s[2], s[1], s[0]);
            end else begin
                drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
            end
            cyc();
            if (c >= 3) begin
                want = {hist[c-3][26:24], hist[c-3][26] ? ref_rgb(hist[c-3][23:0]) : 24'h0};
                n_checks++;
                if ({de_out, h_sync_out, v_sync_out, pixel_out} !== want) begin
                    n_fail++;
                    $display("FAIL random[%0d] in=%h: got %b%b%b %h, want %b %h",
                             c - 3, hist[c-3][23:0], de_out, h_sync_out, v_sync_out,
                             pixel_out, want[26:24], want[23:0]);
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        for (int c = 0; c < 3; c++) begin
            drive(8'd128, 8'd128, 8'd128, 1'b1, 1'b1, 1'b0);
            cyc();
        end
        rst = 1'b1;
        drive(8'd128, 8'd128, 8'd128, 1'b1, 1'b1, 1'b1);
        cyc();
        n_checks++;
        if ({de_out, h_sync_out, v_sync_out, pixel_out} !== 27'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %b%b%b %h, want 000 000000",
                     de_out, h_sync_out, v_sync_out, pixel_out);
        end
        rst = 1'b0;
        drive(8'd255, 8'd128, 8'd128, 1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if ({de_out, h_sync_out, v_sync_out, pixel_out} !== 27'h0) begin
                n_fail++;
                $display("FAIL midreset_hold[%0d]: got %b%b%b %h, want 000 000000",
                         c, de_out, h_sync_out, v_sync_out, pixel_out);
            end
        end
        cyc();
        n_checks++;
        if ({de_out, h_sync_out, v_sync_out, pixel_out} !== {3'b101, 24'hFFFFFF}) begin
            n_fail++;
            $display("FAIL midreset_first: got %b%b%b %h, want 101 ffffff",
                     de_out, h_sync_out, v_sync_out, pixel_out);
        end
        cyc();
        n_checks++;
        if (de_out !== 1'b0 || pixel_out !== 24'h0) begin
            n_fail++;
            $display("FAIL midreset_tail: got de=%b pix=%h, want de=0 pix=000000", de_out, pixel_out);
        end
    endtask

    initial begin
        drive(8'd0, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        test_reset();
        test_latency();
        test_levels();
        test_blanking();
        test_random_stream();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
